// File: rtl/frame_tx_pkg.sv
// frame_tx_pkg: shared types and constants for the frame transmitter.
//   state_t       - packet FSM states
//   *_DEF         - default header / end-marker / pad words
//   TAG_LSB/LOW_LSB - field positions inside header and end-marker words
//   tag_word()    - builds a {tag, low-half} word from the field positions
//   sat_inc16()   - saturating 16-bit increment for error counters
package frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CNT,
    ST_PAY,
    ST_PAD,
    ST_SUM,
    ST_END
  } state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;
  localparam logic [15:0] END_WORD_DEF  = 16'h5AA5;
  localparam logic [31:0] PAD_WORD_DEF  = 32'h0000_0000;

  // Header: tag in [31:16], length in [15:0].
  // End marker: tag in [31:16], truncation flag in bit 0.
  localparam int unsigned TAG_LSB = 16;
  localparam int unsigned LOW_LSB = 0;

  function automatic logic [31:0] tag_word(input logic [15:0] tag,
                                           input logic [15:0] low);
    logic [31:0] w;
    w = '0;
    w[TAG_LSB +: 16] = tag;
    w[LOW_LSB +: 16] = low;
    return w;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_tx_word_to_bytes.sv
// word_to_bytes: 32-bit to 8-bit MSB-first serialiser with valid/ready output.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load, word   - load request and word; taken only when can_load is high
//   can_load     - register empty, or its last byte is accepted this cycle
//   last_accept  - last byte of the held word is accepted this cycle
//   byte_out     - current byte (0 when empty), stable until accepted
//   byte_valid   - byte_out is valid
//   byte_ready   - sink accepts byte_out
module word_to_bytes (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word,
  output logic        can_load,
  output logic        last_accept,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready
);

  logic        full;
  logic [31:0] hold;
  logic [1:0]  idx;

  assign last_accept = full & byte_ready & (idx == 2'd3);
  assign can_load    = ~full | last_accept;
  assign byte_valid  = full;

  always_comb begin
    byte_out = '0;
    if (full) begin
      case (idx)
        2'd0:    byte_out = hold[31:24];
        2'd1:    byte_out = hold[23:16];
        2'd2:    byte_out = hold[15:8];
        default: byte_out = hold[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      hold <= '0;
      idx  <= '0;
    end else if (load && can_load) begin
      full <= 1'b1;
      hold <= word;
      idx  <= '0;
    end else if (full && byte_ready) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) full <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_tx.sv
// frame_tx: wraps each sync period's payload into a packet
//   {SYNC_WORD,len}, frame count, payload (len words), checksum, {END_WORD,trunc}
// and serialises it MSB-first onto an 8-bit valid/ready link.
//   clk, rst_n              - clock, asynchronous active-low reset
//   i_sync_pulse            - one-cycle frame-start pulse
//   i_data_len              - payload word count, valid the cycle after the pulse
//   i_data, i_valid, o_ready- payload word stream
//   o_byte, o_byte_valid,
//   i_byte_ready            - output byte link
//   o_frame_cnt             - completed frames
//   o_trunc_cnt, o_drop_cnt - truncated / dropped frames (saturating)
//   o_busy                  - FSM not idle
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter logic [15:0] END_WORD  = END_WORD_DEF,
  parameter logic [31:0] PAD_WORD  = PAD_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sync_pulse,
  input  logic [15:0] i_data_len,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_trunc_cnt,
  output logic [15:0] o_drop_cnt,
  output logic        o_busy
);

  state_t      state, nxt_state;
  logic        sync_d;
  logic [15:0] len, nxt_len;
  logic [15:0] wcnt, nxt_wcnt;
  logic [15:0] wcnt_inc;
  logic        pending, nxt_pending;
  logic [15:0] pend_len, nxt_pend_len;
  logic        trunc, nxt_trunc;
  logic [31:0] checksum, nxt_checksum;
  logic        end_loaded, nxt_end_loaded;
  logic [31:0] nxt_frame_cnt;
  logic [15:0] nxt_trunc_cnt, nxt_drop_cnt;

  logic        ser_load;
  logic [31:0] ser_word;
  logic        ser_can_load;
  logic        ser_last;

  assign wcnt_inc = wcnt + 16'd1;
  assign o_busy   = (state != ST_IDLE);

  word_to_bytes u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ser_load),
    .word        (ser_word),
    .can_load    (ser_can_load),
    .last_accept (ser_last),
    .byte_out    (o_byte),
    .byte_valid  (o_byte_valid),
    .byte_ready  (i_byte_ready)
  );

  always_comb begin
    nxt_state      = state;
    nxt_len        = len;
    nxt_wcnt       = wcnt;
    nxt_pending    = pending;
    nxt_pend_len   = pend_len;
    nxt_trunc      = trunc;
    nxt_checksum   = checksum;
    nxt_end_loaded = end_loaded;
    nxt_frame_cnt  = o_frame_cnt;
    nxt_trunc_cnt  = o_trunc_cnt;
    nxt_drop_cnt   = o_drop_cnt;
    ser_load       = 1'b0;
    ser_word       = '0;
    o_ready        = 1'b0;

    case (state)
      ST_IDLE: begin
        // A sync seen directly in IDLE starts the frame from i_data_len
        // without a trip through pend_len; this keeps first-byte latency at
        // three cycles while behaving exactly like latch-then-start.
        if (sync_d || pending) begin
          nxt_len        = sync_d ? i_data_len : pend_len;
          nxt_wcnt       = '0;
          nxt_trunc      = 1'b0;
          nxt_checksum   = '0;
          nxt_end_loaded = 1'b0;
          nxt_pending    = 1'b0;
          nxt_state      = ST_HDR;
          if (sync_d) begin
            nxt_pend_len = i_data_len;
            if (pending) nxt_drop_cnt = sat_inc16(o_drop_cnt);
          end
        end
      end

      ST_HDR: begin
        ser_word = tag_word(SYNC_WORD, len);
        if (ser_can_load) begin
          ser_load  = 1'b1;
          nxt_state = ST_CNT;
        end
      end

      ST_CNT: begin
        ser_word = o_frame_cnt;
        if (ser_can_load) begin
          ser_load = 1'b1;
          if (len == '0)  nxt_state = ST_SUM;
          else if (trunc) nxt_state = ST_PAD;
          else            nxt_state = ST_PAY;
        end
      end

      ST_PAY: begin
        // Once truncated, stop taking payload; the remaining words
        // (wcnt < len here) are padded.
        if (trunc) begin
          nxt_state = ST_PAD;
        end else begin
          o_ready  = ser_can_load;
          ser_word = i_data;
          if (i_valid && ser_can_load) begin
            ser_load     = 1'b1;
            nxt_checksum = checksum + i_data;
            nxt_wcnt     = wcnt_inc;
            if (wcnt_inc == len) nxt_state = ST_SUM;
          end
        end
      end

      ST_PAD: begin
        ser_word = PAD_WORD;
        if (ser_can_load) begin
          ser_load = 1'b1;
          nxt_wcnt = wcnt_inc;
          if (wcnt_inc == len) nxt_state = ST_SUM;
        end
      end

      ST_SUM: begin
        ser_word = checksum;
        if (ser_can_load) begin
          ser_load  = 1'b1;
          nxt_state = ST_END;
        end
      end

      ST_END: begin
        ser_word = tag_word(END_WORD, {15'd0, trunc});
        if (!end_loaded) begin
          if (ser_can_load) begin
            ser_load       = 1'b1;
            nxt_end_loaded = 1'b1;
          end
        end else if (ser_last) begin
          nxt_frame_cnt = o_frame_cnt + 32'd1;
          nxt_state     = ST_IDLE;
        end
      end

      default: nxt_state = ST_IDLE;
    endcase

    // Sync arriving while a frame is in flight: queue it, truncating the
    // current frame if its payload is not yet complete.
    if (sync_d && (state != ST_IDLE)) begin
      nxt_pend_len = i_data_len;
      nxt_pending  = 1'b1;
      if (pending) begin
        nxt_drop_cnt = sat_inc16(o_drop_cnt);
      end else if ((state == ST_HDR) || (state == ST_CNT) || (state == ST_PAY)) begin
        nxt_trunc     = 1'b1;
        nxt_trunc_cnt = sat_inc16(o_trunc_cnt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sync_d      <= 1'b0;
      len         <= '0;
      wcnt        <= '0;
      pending     <= 1'b0;
      pend_len    <= '0;
      trunc       <= 1'b0;
      checksum    <= '0;
      end_loaded  <= 1'b0;
      o_frame_cnt <= '0;
      o_trunc_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      state       <= nxt_state;
      sync_d      <= i_sync_pulse;
      len         <= nxt_len;
      wcnt        <= nxt_wcnt;
      pending     <= nxt_pending;
      pend_len    <= nxt_pend_len;
      trunc       <= nxt_trunc;
      checksum    <= nxt_checksum;
      end_loaded  <= nxt_end_loaded;
      o_frame_cnt <= nxt_frame_cnt;
      o_trunc_cnt <= nxt_trunc_cnt;
      o_drop_cnt  <= nxt_drop_cnt;
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
module tb_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_sync_pulse = 1'b0;
  logic [15:0] i_data_len = '0;
  logic [31:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready = 1'b1;
  logic [31:0] o_frame_cnt;
  logic [15:0] o_trunc_cnt;
  logic [15:0] o_drop_cnt;
  logic        o_busy;

  frame_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sync_pulse (i_sync_pulse),
    .i_data_len   (i_data_len),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_frame_cnt  (o_frame_cnt),
    .o_trunc_cnt  (o_trunc_cnt),
    .o_drop_cnt   (o_drop_cnt),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0]  rx_q[$];
  int          rx_cyc[$];
  logic [7:0]  exp_q[$];
  logic [31:0] pay_q[$];
  logic [31:0] acc_q[$];
  int          acc_at[$];
  bit          rand_ready = 0;
  bit          gap_valid = 0;
  bit          stab_en = 0;
  bit          acc_flag = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_byte = '0;
  int          exp_frames = 0;

  // Monitor: evaluated mid-cycle, so every signal is settled for the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stab_en && prev_stall) begin
        checks++;
        if (!o_byte_valid || o_byte !== prev_byte) begin
          errors++;
          $display("FAIL stable_byte: got valid=%0b byte=%02h, required valid=1 byte=%02h",
                   o_byte_valid, o_byte, prev_byte);
        end
      end
      if (i_valid && o_ready) begin
        acc_q.push_back(i_data);
        acc_at.push_back(rx_q.size());
        acc_flag = 1;
      end
      if (o_byte_valid && i_byte_ready) begin
        rx_q.push_back(o_byte);
        rx_cyc.push_back(cyc);
      end
      prev_stall = o_byte_valid && !i_byte_ready;
      prev_byte  = o_byte;
    end else begin
      prev_stall = 0;
    end
  end

  // Payload source and byte sink driver.
  always @(posedge clk) begin
    #1;
    if (acc_flag) begin
      acc_flag = 0;
      if (pay_q.size() > 0) void'(pay_q.pop_front());
    end
    i_byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pay_q.size() > 0 && (!gap_valid || $urandom_range(0, 2) != 0)) begin
      i_valid = 1'b1;
      i_data  = pay_q[0];
    end else begin
      i_valid = 1'b0;
      i_data  = $urandom;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model (packet = words, MSB-first bytes) ----
  task automatic add_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic add_frame(input logic [15:0] len, input logic [31:0] cnt,
                           input logic [31:0] w[$], input int n, input bit tr);
    logic [31:0] sum;
    sum = 0;
    add_word({16'hA55A, len});
    add_word(cnt);
    for (int i = 0; i < int'(len); i++) begin
      if (i < n) begin
        add_word(w[i]);
        sum = sum + w[i];
      end else begin
        add_word(32'h0);
      end
    end
    add_word(sum);
    add_word({16'h5AA5, 15'd0, tr});
  endtask

  function automatic int first_diff();
    int n;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
    if (rx_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sync(input logic [15:0] len, output int t);
    @(posedge clk); #1;
    i_sync_pulse = 1'b1;
    i_data_len   = len;
    t = cyc;
    @(posedge clk); #1;
    i_sync_pulse = 1'b0;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    for (int i = 0; i < 3000 && rx_q.size() < n; i++) @(posedge clk);
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_acc(input int n, output bit ok);
    for (int i = 0; i < 3000 && acc_q.size() < n; i++) @(posedge clk);
    ok = (acc_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!o_busy) break;
    end
    ok = (i < 3000);
    tick(3);
  endtask

  task automatic clear_capture();
    rx_q.delete(); rx_cyc.delete(); exp_q.delete();
    acc_q.delete(); acc_at.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(3);
    rst_n = 1'b1;
    tick(2);
    checks++;
    if ({o_ready, o_byte_valid, o_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got ready/valid/busy=%03b, required 000",
               {o_ready, o_byte_valid, o_busy});
    end
    checks++;
    if ({o_frame_cnt, o_trunc_cnt, o_drop_cnt} !== 64'd0) begin
      errors++;
      $display("FAIL reset_counters: got frame=%0d trunc=%0d drop=%0d, required 0 0 0",
               o_frame_cnt, o_trunc_cnt, o_drop_cnt);
    end
    checks++;
    if (o_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_byte: got %02h, required 00", o_byte);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    int t, d;
    bit ok;
    w = '{32'd1, 32'd2, 32'd3};
    foreach (w[i]) pay_q.push_back(w[i]);
    pulse_sync(16'd3, t);
    add_frame(16'd3, exp_frames, w, 3, 0);
    wait_bytes(exp_q.size(), ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: got %0d bytes, required %0d", rx_q.size(), exp_q.size());
    end
    wait_idle(ok);
    exp_frames++;
    d = first_diff();
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL basic_stream: diff at byte %0d got %02h required %02h (got %0d bytes, required %0d)",
               d, (d < rx_q.size()) ? rx_q[d] : 8'h00, (d < exp_q.size()) ? exp_q[d] : 8'h00,
               rx_q.size(), exp_q.size());
    end
    checks++;
    if (rx_cyc.size() == 0 || rx_cyc[0] != t + 3) begin
      errors++;
      $display("FAIL basic_latency: got first byte at cycle %0d, required %0d",
               (rx_cyc.size() > 0) ? rx_cyc[0] : -1, t + 3);
    end
    checks++;
    if (o_frame_cnt !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL basic_frame_cnt: got %0d, required %0d", o_frame_cnt, exp_frames);
    end
    clear_capture();
  endtask

  task automatic test_len0();
    logic [31:0] none[$];
    int t, d;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      pulse_sync(16'd0, t);
      add_frame(16'd0, exp_frames, none, 0, 0);
      wait_bytes(exp_q.size(), ok);
      wait_idle(ok);
      exp_frames++;
    end
    d = first_diff();
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL len0_stream: diff at byte %0d got %02h required %02h (got %0d bytes, required 32)",
               d, (d < rx_q.size()) ? rx_q[d] : 8'h00, (d < exp_q.size()) ? exp_q[d] : 8'h00,
               rx_q.size());
    end
    checks++;
    if (o_frame_cnt !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL len0_frame_cnt: got %0d, required %0d", o_frame_cnt, exp_frames);
    end
    clear_capture();
  endtask

  task automatic test_gaps();
    logic [31:0] w[$];
    logic [15:0] lens[2];
    int t, d, nw;
    bit ok;
    lens[0] = 16'd8;
    lens[1] = 16'($urandom_range(1, 6));
    rand_ready = 1; gap_valid = 1; stab_en = 1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < int'(lens[k]); i++) begin
        w.push_back($urandom);
        pay_q.push_back(w[w.size() - 1]);
      end
    end
    nw = 0;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] fw[$];
      for (int i = 0; i < int'(lens[k]); i++) fw.push_back(w[nw + i]);
      nw += int'(lens[k]);
      pulse_sync(lens[k], t);
      add_frame(lens[k], exp_frames, fw, int'(lens[k]), 0);
      wait_bytes(exp_q.size(), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL gaps_timeout: got %0d bytes, required %0d", rx_q.size(), exp_q.size());
      end
      wait_idle(ok);
      exp_frames++;
    end
    rand_ready = 0; gap_valid = 0; stab_en = 0;
    d = first_diff();
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL gaps_stream: diff at byte %0d got %02h required %02h (got %0d bytes, required %0d)",
               d, (d < rx_q.size()) ? rx_q[d] : 8'h00, (d < exp_q.size()) ? exp_q[d] : 8'h00,
               rx_q.size(), exp_q.size());
    end
    checks++;
    if (acc_q != w) begin
      errors++;
      $display("FAIL gaps_payload_order: got %0d accepted words, required %0d in order",
               acc_q.size(), w.size());
    end
    clear_capture();
  endtask

  task automatic test_trunc();
    logic [31:0] w1[$], w2[$];
    int t, d;
    bit ok;
    for (int i = 0; i < 5; i++) w1.push_back($urandom);
    for (int i = 0; i < 2; i++) w2.push_back($urandom);
    pay_q.push_back(w1[0]);
    pay_q.push_back(w1[1]);
    pulse_sync(16'd5, t);
    wait_acc(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL trunc_first_words: got %0d accepted, required 2", acc_q.size());
    end
    tick(3);
    pulse_sync(16'd2, t);
    tick(1);
    foreach (w2[i]) pay_q.push_back(w2[i]);
    add_frame(16'd5, exp_frames, w1, 2, 1);
    add_frame(16'd2, exp_frames + 1, w2, 2, 0);
    wait_bytes(exp_q.size(), ok);
    wait_idle(ok);
    exp_frames += 2;
    d = first_diff();
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL trunc_stream: diff at byte %0d got %02h required %02h (got %0d bytes, required %0d)",
               d, (d < rx_q.size()) ? rx_q[d] : 8'h00, (d < exp_q.size()) ? exp_q[d] : 8'h00,
               rx_q.size(), exp_q.size());
    end
    checks++;
    if (o_trunc_cnt !== 16'd1) begin
      errors++;
      $display("FAIL trunc_cnt: got %0d, required 1", o_trunc_cnt);
    end
    // Second frame's first word may only be taken at the end of its CNT word.
    checks++;
    if (acc_at.size() != 4 || acc_at[2] < 43) begin
      errors++;
      $display("FAIL trunc_holdoff: got %0d accepts, third at byte %0d, required 4 accepts, third at >=43",
               acc_at.size(), (acc_at.size() > 2) ? acc_at[2] : -1);
    end
    clear_capture();
  endtask

  task automatic test_drop();
    logic [31:0] wa[$], wb[$];
    int t, d;
    bit ok;
    wa.push_back($urandom);
    wb.push_back($urandom);
    wb.push_back($urandom);
    pay_q.push_back(wa[0]);
    pulse_sync(16'd1, t);
    wait_bytes(9, ok);
    pulse_sync(16'd4, t);
    pulse_sync(16'd2, t);
    foreach (wb[i]) pay_q.push_back(wb[i]);
    add_frame(16'd1, exp_frames, wa, 1, 0);
    add_frame(16'd2, exp_frames + 1, wb, 2, 0);
    wait_bytes(exp_q.size(), ok);
    wait_idle(ok);
    exp_frames += 2;
    d = first_diff();
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL drop_stream: diff at byte %0d got %02h required %02h (got %0d bytes, required %0d)",
               d, (d < rx_q.size()) ? rx_q[d] : 8'h00, (d < exp_q.size()) ? exp_q[d] : 8'h00,
               rx_q.size(), exp_q.size());
    end
    checks++;
    if (o_drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_cnt: got %0d, required 1", o_drop_cnt);
    end
    checks++;
    if (o_frame_cnt !== 32'(exp_frames) || o_trunc_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_other_counters: got frame=%0d trunc=%0d, required frame=%0d trunc=1",
               o_frame_cnt, o_trunc_cnt, exp_frames);
    end
    clear_capture();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[$];
    int t, d;
    bit ok;
    pay_q.push_back($urandom);
    pay_q.push_back($urandom);
    pulse_sync(16'd6, t);
    wait_acc(2, ok);
    tick(2);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy_before: got %0b, required 1", o_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_byte_valid, o_busy, o_byte} !== 11'd0 ||
        {o_frame_cnt, o_trunc_cnt, o_drop_cnt} !== 64'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got ready=%0b valid=%0b busy=%0b byte=%02h frame=%0d trunc=%0d drop=%0d, required all 0",
               o_ready, o_byte_valid, o_busy, o_byte, o_frame_cnt, o_trunc_cnt, o_drop_cnt);
    end
    tick(2);
    pay_q.delete();
    clear_capture();
    exp_frames = 0;
    rst_n = 1'b1;
    tick(2);
    w.push_back($urandom);
    w.push_back($urandom);
    foreach (w[i]) pay_q.push_back(w[i]);
    pulse_sync(16'd2, t);
    add_frame(16'd2, 32'd0, w, 2, 0);
    wait_bytes(exp_q.size(), ok);
    wait_idle(ok);
    exp_frames++;
    d = first_diff();
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL rstmid_stream: diff at byte %0d got %02h required %02h (got %0d bytes, required %0d)",
               d, (d < rx_q.size()) ? rx_q[d] : 8'h00, (d < exp_q.size()) ? exp_q[d] : 8'h00,
               rx_q.size(), exp_q.size());
    end
    checks++;
    if (o_frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rstmid_frame_cnt: got %0d, required 1", o_frame_cnt);
    end
    clear_capture();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_gaps();
    test_trunc();
    test_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
